seq_divider8: RTL and testbench
===============================

Name: seq_divider8

Overview:
- Sequential unsigned radix-2 restoring divider; the inverse operation of the team's 8-bit Dadda multiplier.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one bit per clock.
- Sits beside the multiplier in the arithmetic library; a start/busy/done handshake lets a controller issue one division at a time.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- dividend  in  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  in  WIDTH  unsigned divisor; captured on the accepting edge.
- busy  out  1  high while a division is in progress (RUN state).
- done  out  1  one-cycle pulse; results are valid from this cycle.
- quotient  out  WIDTH  result quotient; held until the next result.
- remainder  out  WIDTH  result remainder; held until the next result.
- div_by_zero  out  1  flag for the current result; held with it.

Behaviour:
- Reset, asynchronous and immediate:
  - state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Iteration counter and working registers cleared.
  - Reset mid-RUN aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and divisor!=0: capture operands, partial remainder=0, count=0, go to RUN.
  - start=1 and divisor==0: go straight to DONE. Update quotient to all ones, remainder to dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- RUN: busy=1 for every RUN cycle. Each edge performs one restoring step:
  - shift {partial remainder, dividend reg} left by 1;
  - trial = partial remainder − divisor, computed WIDTH+1 bits wide;
  - if non-negative, keep trial and shift in quotient bit 1; otherwise restore and shift in 0;
  - count++.
  - After the WIDTH-th step, go to DONE and load the quotient/remainder output registers. Clear div_by_zero.
- DONE: done=1 for exactly one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, so back-to-back operation is possible.
- Latency: start high in cycle 0 gives done high in cycle WIDTH+1 (cycle 9 for WIDTH=8). Divide-by-zero gives done in cycle 1.
- Output registers change only on DONE entry. They are stable during RUN and show the previous result.
- start while busy=1 is ignored. Operands on dividend/divisor may change freely after the accepting edge.
- Arithmetic invariant for divisor!=0: dividend == quotient*divisor + remainder, with remainder < divisor.
- No X propagation: every register has a reset value.

Decomposition:
- Shared package `arith_pkg`:
  - state enum {IDLE, RUN, DONE};
  - localparam CNT_W = $clog2(WIDTH+1);
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module, `div_restore_step`: purely combinational.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder and quotient bit.
  - Instantiated once and used iteratively by the FSM.

Test Plan:
- 200/7, start pulse in cycle 0 → busy cycles 1-8; done in cycle 9 only; quotient=28, remainder=4, div_by_zero=0.
- 255/1 then 5/9, second start issued in the done cycle of the first → 255 r0, then 0 r5. The second done follows exactly 9 cycles after the first.
- 13/0 → done in cycle 1; quotient=255, remainder=13, div_by_zero=1; busy never high. Next division 100/10 → 10 r0 with div_by_zero cleared.
- start pulsed with 9/3 in cycle 4 of an active 100/7 run → ignored; result 14 r2, single done pulse.
- rst asserted in cycle 5 of 250/3 → all outputs 0 asynchronously; no done. A fresh 250/3 then yields 83 r1.
- Random sweep (≥10k unsigned pairs, WIDTH=8) → invariant check against the reference model; divisor-zero cases checked separately.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM states, counter sizing
// and the quotient value reported for a division by zero.
package arith_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Widest operand the library supports
  localparam int MAX_WIDTH = 32;

  // Default operand width and the matching iteration counter width
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  // Quotient reported when the divisor is zero (all ones, sliced to width)
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = {MAX_WIDTH{1'b1}};

  // Counter width able to hold the values 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_part_rem,
  input  logic             i_next_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_part_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in WIDTH+1 bits and the trial difference sign is its MSB.
  assign w_shifted = {i_part_rem, i_next_bit};
  assign w_trial   = w_shifted - {1'b0, i_divisor};

  // Keep the trial difference when non-negative, otherwise restore
  always_comb begin
    o_q_bit    = ~w_trial[WIDTH];
    o_part_rem = w_shifted[WIDTH-1:0];
    if (o_q_bit) begin
      o_part_rem = w_trial[WIDTH-1:0];
    end else begin
      o_part_rem = w_shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider8.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// with a start/busy/done handshake and a divide-by-zero flag.
module seq_divider8
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int C_CNT_W = cnt_width(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST_STEP = C_CNT_W'(WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

  div_state_e         r_state;
  logic [WIDTH-1:0]   r_part_rem;
  logic [WIDTH-1:0]   r_dividend;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_divisor;
  logic [C_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;

  div_state_e         w_state_nxt;
  logic [WIDTH-1:0]   w_part_rem_nxt;
  logic [WIDTH-1:0]   w_dividend_nxt;
  logic [WIDTH-1:0]   w_divisor_nxt;
  logic [C_CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0]   w_quotient_nxt;
  logic [WIDTH-1:0]   w_remainder_nxt;
  logic               w_dbz_nxt;

  logic [WIDTH-1:0]   w_step_rem;
  logic               w_step_qbit;

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_part_rem (r_part_rem),
    .i_next_bit (r_dividend[WIDTH-1]),
    .i_divisor  (r_divisor),
    .o_part_rem (w_step_rem),
    .o_q_bit    (w_step_qbit)
  );

  // Next-state and datapath-update decode; results only change on DONE entry
  always_comb begin
    w_state_nxt     = r_state;
    w_part_rem_nxt  = r_part_rem;
    w_dividend_nxt  = r_dividend;
    w_divisor_nxt   = r_divisor;
    w_count_nxt     = r_count;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
    w_dbz_nxt       = r_dbz;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          if (divisor != {WIDTH{1'b0}}) begin
            w_state_nxt    = RUN;
            w_part_rem_nxt = {WIDTH{1'b0}};
            w_dividend_nxt = dividend;
            w_divisor_nxt  = divisor;
            w_count_nxt    = {C_CNT_W{1'b0}};
          end else begin
            w_state_nxt     = DONE;
            w_quotient_nxt  = DBZ_QUOTIENT[WIDTH-1:0];
            w_remainder_nxt = dividend;
            w_dbz_nxt       = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_part_rem_nxt = w_step_rem;
        w_dividend_nxt = {r_dividend[WIDTH-2:0], w_step_qbit};
        w_count_nxt    = r_count + C_CNT_ONE;
        if (r_count == C_LAST_STEP) begin
          w_state_nxt     = DONE;
          w_quotient_nxt  = {r_dividend[WIDTH-2:0], w_step_qbit};
          w_remainder_nxt = w_step_rem;
          w_dbz_nxt       = 1'b0;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_part_rem  <= {WIDTH{1'b0}};
      r_dividend  <= {WIDTH{1'b0}};
      r_divisor   <= {WIDTH{1'b0}};
      r_count     <= {C_CNT_W{1'b0}};
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_dbz       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_part_rem  <= w_part_rem_nxt;
      r_dividend  <= w_dividend_nxt;
      r_divisor   <= w_divisor_nxt;
      r_count     <= w_count_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
      r_dbz       <= w_dbz_nxt;
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: directed table, handshake corner
// sequences and a randomized sweep against an arithmetic reference model.
module tb_seq_divider8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  seq_divider8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one division and wait (bounded) for done; returns in the done cycle.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int nbusy, output int unstable);
    logic [7:0] pq;
    logic [7:0] pr;
    pq = quotient;
    pr = remainder;
    start = 1'b1;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
    lat = 1;
    nbusy = 0;
    unstable = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      if (quotient !== pq || remainder !== pr) unstable++;
      tick();
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  initial begin
    vec_t tbl[12];
    int lat, nbusy, unst, cyc, ndone, done_cyc;
    logic [7:0] cq, cr;
    logic [7:0] a, b;
    int exp_q, exp_r, exp_lat;
    logic exp_dbz;

    tbl[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    tbl[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    tbl[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    tbl[3]  = '{8'd13,  8'd0,   8'd255, 8'd13,  1'b1};
    tbl[4]  = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0};
    tbl[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    tbl[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    tbl[7]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
    tbl[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
    tbl[9]  = '{8'd255, 8'd0,   8'd255, 8'd255, 1'b1};
    tbl[10] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
    tbl[11] = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0};

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    tick();
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_div(tbl[i].a, tbl[i].b, lat, nbusy, unst);
      check($sformatf("tbl%0d_quot", i), quotient, tbl[i].q);
      check($sformatf("tbl%0d_rem", i), remainder, tbl[i].r);
      check($sformatf("tbl%0d_dbz", i), div_by_zero, tbl[i].dbz);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].dbz ? 1 : 9);
      check($sformatf("tbl%0d_busycycles", i), nbusy, tbl[i].dbz ? 0 : 8);
      check($sformatf("tbl%0d_busy_at_done", i), busy, 0);
      check($sformatf("tbl%0d_hold", i), unst, 0);
      tick();
      check($sformatf("tbl%0d_done_pulse", i), done, 0);
    end

    // Back-to-back: second start in the done cycle of the first
    run_div(8'd255, 8'd1, lat, nbusy, unst);
    check("b2b1_quot", quotient, 255);
    check("b2b1_rem", remainder, 0);
    run_div(8'd5, 8'd9, lat, nbusy, unst);
    check("b2b2_lat", lat, 9);
    check("b2b2_quot", quotient, 0);
    check("b2b2_rem", remainder, 5);
    tick();

    // Divide by zero, then a normal division clears the flag
    run_div(8'd13, 8'd0, lat, nbusy, unst);
    check("dbz_lat", lat, 1);
    check("dbz_quot", quotient, 255);
    check("dbz_rem", remainder, 13);
    check("dbz_flag", div_by_zero, 1);
    check("dbz_nobusy", nbusy, 0);
    tick();
    run_div(8'd100, 8'd10, lat, nbusy, unst);
    check("after_dbz_quot", quotient, 10);
    check("after_dbz_rem", remainder, 0);
    check("after_dbz_flag", div_by_zero, 0);
    tick();

    // Start while busy is ignored
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    tick();
    start = 1'b0;
    cyc = 5; ndone = 0; done_cyc = -1; cq = 8'd0; cr = 8'd0;
    while (cyc < 14) begin
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc; cq = quotient; cr = remainder;
        end
      end
      tick();
      cyc++;
    end
    check("ign_ndone", ndone, 1);
    check("ign_done_cyc", done_cyc, 9);
    check("ign_quot", cq, 14);
    check("ign_rem", cr, 2);

    // Reset mid-run aborts; outputs clear asynchronously
    start = 1'b1; dividend = 8'd250; divisor = 8'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_quot", quotient, 0);
    check("arst_rem", remainder, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("arst_no_done", ndone, 0);
    run_div(8'd250, 8'd3, lat, nbusy, unst);
    check("arst_fresh_quot", quotient, 83);
    check("arst_fresh_rem", remainder, 1);
    check("arst_fresh_lat", lat, 9);
    tick();

    // Randomized sweep, back-to-back, against the arithmetic model
    for (int n = 0; n < 10000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_div(a, b, lat, nbusy, unst);
      if (b == 8'd0) begin
        exp_q = 255; exp_r = int'(a); exp_dbz = 1'b1; exp_lat = 1;
      end else begin
        exp_q = int'(a) / int'(b); exp_r = int'(a) % int'(b); exp_dbz = 1'b0; exp_lat = 9;
      end
      check("rand_quot", quotient, exp_q);
      check("rand_rem", remainder, exp_r);
      check("rand_dbz", div_by_zero, exp_dbz);
      check("rand_lat", lat, exp_lat);
      if (b != 8'd0) begin
        check("rand_invariant",
              ((int'(quotient) * int'(b) + int'(remainder)) == int'(a)) && (remainder < b), 1);
      end
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
